// File: rtl/cache_pkg.sv
// cache_pkg: widths, line-address type and fill FSM encoding shared by the
// miss-fill path (cache_fill_unit and its request FIFO).
package cache_pkg;

    localparam int ADDR_W     = 20;               // byte address width
    localparam int LINE_W     = 128;              // cache line width
    localparam int BEAT_W     = 32;               // memory read beat width
    localparam int LINE_OFF_W = 4;                // byte offset bits inside a line
    localparam int TAG_W      = ADDR_W - LINE_OFF_W;
    localparam int BEATS      = LINE_W / BEAT_W;  // beats per line
    localparam int BEAT_CNT_W = $clog2(BEATS);

    typedef logic [TAG_W-1:0] line_addr_t;

    typedef enum logic [1:0] {
        FILL_IDLE  = 2'd0,
        FILL_REQ   = 2'd1,
        FILL_BEATS = 2'd2,
        FILL_DONE  = 2'd3
    } fill_state_t;

    // Expand a line address back into a line-aligned byte address.
    function automatic logic [ADDR_W-1:0] line_to_byte(input line_addr_t la);
        return {la, {LINE_OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/fill_req_fifo.sv
// fill_req_fifo: small queue of pending miss line addresses. Exposes the head
// entry plus a parallel compare of the incoming address against every valid
// entry (head included) so the caller can drop duplicate misses.
module fill_req_fifo
    import cache_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  line_addr_t push_addr_i,
    input  logic       pop_i,
    output line_addr_t head_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       match_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    line_addr_t       entry_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_next;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // Pointer advance with explicit wrap so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = entry_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Per-entry valid bits: pop clears the head slot, push sets the tail slot.
    always_comb begin
        vld_next = vld_q;
        if (do_pop)  vld_next[rd_ptr_q] = 1'b0;
        if (do_push) vld_next[wr_ptr_q] = 1'b1;
    end

    // Duplicate detect: incoming address against every occupied slot.
    always_comb begin
        match_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (entry_q[i] == push_addr_i)) match_o = 1'b1;
        end
    end

    // Storage, pointers and occupancy; push and pop may share an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
            vld_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            vld_q <= vld_next;
            if (do_push) begin
                entry_q[wr_ptr_q] <= push_addr_i;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cache_fill_unit.sv
// cache_fill_unit: miss-fill stage behind the cache lookup. Queues miss line
// addresses, reads each line from memory as four beats and returns it with a
// one-cycle fill_valid_o pulse.
// Optional build macro: CACHE_FILL_TIMEOUT_EN adds a per-transaction watchdog
// that pulses timeout_o and reissues the same request after TIMEOUT cycles.
//
// Memory handshake: mem_req_o is raised with mem_addr_o and both are held
// stable until the first rising edge that sees mem_ack_i=1 (the request is
// accepted on that edge). After acceptance each edge with mem_rvalid_i=1
// delivers one beat, word 0 first; beats may arrive with arbitrary gaps and
// there is no backpressure on them. mem_rvalid_i outside a read is ignored.
module cache_fill_unit
    import cache_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rqst_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              busy_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic              mem_rvalid_i,
    input  logic [BEAT_W-1:0] mem_rdata_i,
    output logic              fill_valid_o,
    output logic [ADDR_W-1:0] fill_addr_o,
    output logic [LINE_W-1:0] fill_data_o,
    output logic              timeout_o
);

    fill_state_t                       state_q;
    logic [BEAT_CNT_W-1:0]             beat_cnt_q;
    logic [BEATS-2:0][BEAT_W-1:0]      beat_buf_q;  // words 0..2; word 3 goes straight to fill_data_o
    line_addr_t                        head;
    line_addr_t                        rqst_line;
    logic                              fifo_full;
    logic                              fifo_empty;
    logic                              fifo_match;
    logic                              push;
    logic                              pop;
    logic                              last_beat;
    logic                              tmo_hit;
    logic                              unused_addr_bits;

    assign rqst_line        = addr_i[ADDR_W-1:LINE_OFF_W];
    assign unused_addr_bits = ^addr_i[LINE_OFF_W-1:0];

    // A miss already queued or in flight is not fetched twice.
    assign push = rqst_i && !fifo_full && !fifo_match;
    assign pop  = (state_q == FILL_DONE);

    assign busy_o       = fifo_full;
    assign mem_req_o    = (state_q == FILL_REQ);
    assign fill_valid_o = (state_q == FILL_DONE);
    assign last_beat    = (state_q == FILL_BEATS) && mem_rvalid_i &&
                          (beat_cnt_q == BEAT_CNT_W'(BEATS - 1));

    fill_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_addr_i (rqst_line),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .match_o     (fifo_match)
    );

`ifdef CACHE_FILL_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_active;

    assign tmo_active = (state_q == FILL_REQ) || (state_q == FILL_BEATS);
    // A completing last beat wins over an expiring counter on the same edge.
    assign tmo_hit    = tmo_active && (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) && !last_beat;

    // Watchdog: restarts on every entry to REQ, counts while a read is open.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= tmo_hit;
            if (tmo_hit || ((state_q == FILL_IDLE) && !fifo_empty)) begin
                tmo_cnt_q <= '0;
            end else if (tmo_active) begin
                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;

    assign tmo_hit   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Fill FSM: issue request, collect beats, publish the line, pop the head.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= FILL_IDLE;
            beat_cnt_q  <= '0;
            beat_buf_q  <= '0;
            mem_addr_o  <= '0;
            fill_addr_o <= '0;
            fill_data_o <= '0;
        end else if (tmo_hit) begin
            // Abandon the partial line and reissue the same head.
            state_q    <= FILL_REQ;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                FILL_IDLE: begin
                    if (!fifo_empty) begin
                        state_q    <= FILL_REQ;
                        mem_addr_o <= line_to_byte(head);
                    end
                end
                FILL_REQ: begin
                    if (mem_ack_i) begin
                        state_q    <= FILL_BEATS;
                        beat_cnt_q <= '0;
                    end
                end
                FILL_BEATS: begin
                    if (mem_rvalid_i) begin
                        beat_cnt_q <= beat_cnt_q + BEAT_CNT_W'(1);
                        if (last_beat) begin
                            state_q     <= FILL_DONE;
                            fill_addr_o <= line_to_byte(head);
                            fill_data_o <= {mem_rdata_i, beat_buf_q};
                        end else begin
                            beat_buf_q[beat_cnt_q] <= mem_rdata_i;
                        end
                    end
                end
                FILL_DONE: begin
                    state_q <= FILL_IDLE;
                end
                default: begin
                    state_q <= FILL_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cache_fill_unit.md
Name: cache_fill_unit

Overview:
- Miss-fill stage directly downstream of the cache lookup block.
- Accepts the lookup's miss request (rqst_to_mem pulse plus address) and queues it.
- Fetches the 128-bit line from memory as four 32-bit beats over a req/ack + rvalid interface.
- Returns the assembled line with a one-cycle ready pulse and line address, wired to the lookup's mem_data_ready_i / mem_addr_i.

Parameters:
- ADDR_W, 20, byte address width.
- LINE_W, 128, cache line width in bits.
- BEAT_W, 32, memory read beat width (LINE_W/BEAT_W = 4 beats).
- FIFO_DEPTH, 2, pending miss request entries.
- TIMEOUT, 64, cycles allowed per memory transaction (used only with the optional feature).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- rqst_i  in  1  miss request pulse from lookup.
- addr_i  in  ADDR_W  miss byte address from lookup.
- busy_o  out  1  request FIFO full; rqst_i is ignored while high.
- mem_req_o  out  1  memory read request, held until accepted.
- mem_addr_o  out  ADDR_W  line-aligned address, bits [3:0]=0.
- mem_ack_i  in  1  memory accepted the request.
- mem_rvalid_i  in  1  read beat valid.
- mem_rdata_i  in  BEAT_W  read beat data, word 0 first.
- fill_valid_o  out  1  one-cycle pulse: line complete.
- fill_addr_o  out  ADDR_W  line-aligned address of the completed fill.
- fill_data_o  out  LINE_W  assembled line; holds until the next fill.
- timeout_o  out  1  one-cycle pulse on transaction timeout.

Behaviour:
- Reset (async, rst_i=1): all of the following are cleared.
  - FIFO emptied; FSM to IDLE.
  - mem_req_o=0, mem_addr_o=0, fill_valid_o=0, fill_addr_o=0, fill_data_o=0, timeout_o=0, busy_o=0.
  - Beat counter=0; timeout counter=0.
- Enqueue:
  - On a rising edge with rqst_i=1 and busy_o=0, line address addr_i[19:4] is pushed.
  - Duplicate rule: if that line address matches any valid FIFO entry (including the in-flight head), the request is dropped.
  - rqst_i while busy_o=1 is dropped. Upstream guarantees at most FIFO_DEPTH outstanding misses.
- FSM states: IDLE, REQ, BEATS, DONE.
  - IDLE: if FIFO is non-empty, go to REQ at the next edge. mem_req_o rises one cycle after the enqueue edge.
  - REQ: mem_req_o=1 and mem_addr_o={head,4'b0}, held stable. At an edge with mem_ack_i=1, go to BEATS with beat_cnt=0.
  - BEATS: each edge with mem_rvalid_i=1 writes mem_rdata_i into buffer[32*beat_cnt +: 32] and increments beat_cnt (2-bit, wraps). The edge capturing beat 3 goes to DONE. mem_rvalid_i is ignored in IDLE and REQ.
  - DONE: one cycle with fill_valid_o=1 and fill_addr_o={head,4'b0}. fill_data_o is updated from the buffer at entry to DONE. Head is popped on the same edge; go to IDLE.
- Latency: fill_valid_o is asserted the cycle after the edge capturing the last beat.
- Simultaneous push and pop in DONE: both take effect. busy_o reflects the resulting occupancy.
- A push whose address matches the head being popped that same edge is still a duplicate and is dropped.
- Gaps between beats are allowed; there is no maximum gap without the optional feature.
- Reset mid-transaction discards the partial line. Beats still arriving after reset are ignored because the FSM is in IDLE.

Optional Feature:
- Macro: CACHE_FILL_TIMEOUT_EN.
- Defined: a counter clears on entering REQ and increments every cycle in REQ/BEATS.
  - On reaching TIMEOUT-1 without completing: timeout_o pulses for one cycle, beat_cnt is cleared, the FSM returns to REQ, and the same head is reissued.
  - No fill is signalled for the aborted attempt.
- Undefined: no counter is instantiated, timeout_o is tied to 0, and transactions wait indefinitely.

Decomposition:
- Shared package cache_pkg:
  - ADDR_W, LINE_W, BEAT_W.
  - LINE_OFF_W=4, TAG_W=ADDR_W-LINE_OFF_W.
  - Typedef line_addr_t [TAG_W-1:0].
  - FSM state enum fill_state_t.
- One sub-module, fill_req_fifo: FIFO_DEPTH entries of line_addr_t with push, pop, head, full, empty, and a parallel match output for duplicate detection.

Test Plan:
- Single miss: rqst_i with addr_i=0x12345; ack 2 cycles later; beats 0xA,0xB,0xC,0xD back-to-back -> mem_addr_o=0x12340; fill_valid_o one cycle after the 4th beat; fill_addr_o=0x12340; fill_data_o=0x0000000D_0000000C_0000000B_0000000A.
- Duplicate drop: rqst_i for 0x00100, then 0x0010C while the first is in flight -> exactly one memory request and one fill; busy_o stays 0.
- Full and queueing: misses 0x00010, 0x00020 (FIFO full, busy_o=1), then a third request 0x00030 -> third dropped; fills for 0x00010 then 0x00020 in order; busy_o drops the cycle after the first pop.
- Beat gaps and backpressure: mem_ack_i held low for 5 cycles, with 3 idle cycles between beats 1 and 2 -> mem_req_o and mem_addr_o stable throughout; line assembled correctly; single fill pulse.
- Reset mid-fill: assert rst_i after 2 beats, release, send 2 stray rvalid beats -> no fill_valid_o; all outputs 0; a new request afterwards completes normally.
- With CACHE_FILL_TIMEOUT_EN and TIMEOUT=8: never ack -> timeout_o pulses every 8 cycles and mem_req_o is reissued with the same address. Without the macro: timeout_o stays 0 and mem_req_o stays high.
